// File: rtl/mem_bus_decoder_n.sv
// -----------------------------------------------------------------------------
// mem_bus_decoder_n
// One-initiator to NUM_TARGETS-target memory bus decoder.
//
// A request in IDLE is decoded against a table of base/mask windows. The
// lowest matching index wins. On a hit, the target index is registered and
// the block moves to ACTIVE. The target then sees the window offset and the
// live write data and strobes until it returns ready. On a miss, the block
// answers with a one-cycle error response (ERR_RDATA). It also records the
// faulting address and the cause for firmware.
//
// Optional build macro: MEM_BUS_TIMEOUT_EN
//   When defined, a counter limits how long ACTIVE waits for the selected
//   target. The limit is TIMEOUT_CYCLES. When the counter expires, the
//   request is aborted with an error response and cause 2. When the macro
//   is undefined, ACTIVE waits indefinitely.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   s_valid_i        initiator request valid
//   s_ready_o        transfer completes this cycle (s_rdata_o valid)
//   s_addr_i         request address
//   s_wdata_i        write data
//   s_we_i           byte write strobes, all zero for a read
//   s_rdata_o        read data, zero whenever s_ready_o is low
//   m_valid_o        per-target valid, one-hot or zero
//   m_ready_i        per-target ready
//   m_addr_o         shared address, offset inside the selected window
//   m_wdata_o        shared write data
//   m_we_o           shared strobes, zero outside ACTIVE
//   m_rdata_i        per-target read data, packed, target i at slice i
//   err_o            one-cycle pulse on each error response
//   err_addr_o       address of the most recent error (sticky)
//   err_cause_o      cause of the most recent error: 0 none, 1 miss, 2 timeout
// -----------------------------------------------------------------------------
module mem_bus_decoder_n #(
    parameter int NUM_TARGETS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_BASE =
        {32'h8000_0100, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_MASK =
        {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEAD_BEEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_valid_i,
    output logic                              s_ready_o,
    input  logic [ADDR_WIDTH-1:0]             s_addr_i,
    input  logic [DATA_WIDTH-1:0]             s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]           s_we_i,
    output logic [DATA_WIDTH-1:0]             s_rdata_o,
    output logic [NUM_TARGETS-1:0]            m_valid_o,
    input  logic [NUM_TARGETS-1:0]            m_ready_i,
    output logic [ADDR_WIDTH-1:0]             m_addr_o,
    output logic [DATA_WIDTH-1:0]             m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]           m_we_o,
    input  logic [NUM_TARGETS*DATA_WIDTH-1:0] m_rdata_i,
    output logic                              err_o,
    output logic [ADDR_WIDTH-1:0]             err_addr_o,
    output logic [1:0]                        err_cause_o
);

    localparam int SEL_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_e;

    state_e                   state_r;
    state_e                   state_nxt_s;
    logic [SEL_W-1:0]         sel_r;
    logic [SEL_W-1:0]         sel_nxt_s;
    logic [NUM_TARGETS-1:0]   match_s;
    logic                     hit_s;
    logic [SEL_W-1:0]         hit_idx_s;
    logic                     sel_ready_s;
    logic                     timeout_hit_s;
    logic [1:0]               cause_s;
    logic [ADDR_WIDTH-1:0]    err_addr_r;
    logic [1:0]               err_cause_r;

    // Window match per target, then a priority pick with the lowest index first
    always_comb begin
        match_s   = '0;
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            match_s[i] = ((s_addr_i & TARGET_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                          == TARGET_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]);
            hit_idx_s  = (match_s[i] && !hit_s) ? SEL_W'(i) : hit_idx_s;
            hit_s      = hit_s | match_s[i];
        end
    end

    assign sel_ready_s = m_ready_i[sel_r];

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

    logic [CNT_W-1:0] to_cnt_r;
    logic             to_pend_r;

    // The counter holds zero outside ACTIVE, so it starts clean on every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r  <= '0;
            to_pend_r <= 1'b0;
        end else begin
            if (state_r != ST_ACTIVE) begin
                to_cnt_r <= '0;
            end else if (!sel_ready_s) begin
                to_cnt_r <= to_cnt_r + CNT_W'(1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            // Remembers that the coming ERR cycle is a timeout, not a miss
            to_pend_r <= (state_r == ST_ACTIVE) && (state_nxt_s == ST_ERR);
        end
    end

    // The last waiting cycle is the one whose increment would reach the limit
    assign timeout_hit_s = (to_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cause_s       = to_pend_r ? 2'd2 : 2'd1;
`else
    assign timeout_hit_s = 1'b0;
    assign cause_s       = 2'd1;
`endif

    // Next-state and target-select logic
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        case (state_r)
            ST_IDLE: begin
                if (s_valid_i) begin
                    if (hit_s) begin
                        sel_nxt_s   = hit_idx_s;
                        state_nxt_s = ST_ACTIVE;
                    end else begin
                        state_nxt_s = ST_ERR;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                // A target ready on the terminal count still wins
                if (sel_ready_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_ERR:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Initiator and target outputs decoded from the current state
    always_comb begin
        s_ready_o = 1'b0;
        s_rdata_o = '0;
        m_valid_o = '0;
        m_we_o    = '0;
        err_o     = 1'b0;
        case (state_r)
            ST_ACTIVE: begin
                m_valid_o[sel_r] = 1'b1;
                m_we_o           = s_we_i;
                s_ready_o        = sel_ready_s;
                if (sel_ready_s) begin
                    s_rdata_o = m_rdata_i[int'(sel_r)*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    s_rdata_o = '0;
                end
            end
            ST_ERR: begin
                s_ready_o = 1'b1;
                s_rdata_o = ERR_RDATA;
                err_o     = 1'b1;
            end
            default: begin
                s_ready_o = 1'b0;
            end
        endcase
    end

    assign m_addr_o  = s_addr_i & ~TARGET_MASK[int'(sel_r)*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_wdata_o = s_wdata_i;

    // State, select and sticky error capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sel_r       <= '0;
            err_addr_r  <= '0;
            err_cause_r <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            if (state_r == ST_ERR) begin
                err_addr_r  <= s_addr_i;
                err_cause_r <= cause_s;
            end else begin
                err_addr_r  <= err_addr_r;
                err_cause_r <= err_cause_r;
            end
        end
    end

    assign err_addr_o  = err_addr_r;
    assign err_cause_o = err_cause_r;

endmodule
